ov7670_power_seq: RTL and testbench

Parametrised power-up and reset sequencer for the OV7670 camera. It replaces the single fixed 24-bit delay counter with a staged sequence:
- drive PWDN, then drive RESETB,
- wait for the sensor to settle,
- request SCCB configuration and supervise it with a timeout and a bounded retry count.

It sits between the board enable and the camera pins / SCCB config engine, and gates the capture path via `ready`.

---
 rtl/ov7670_power_seq_pkg.sv | 53 +++++
 rtl/ov7670_power_seq_if.sv | 27 ++
 rtl/ov7670_power_seq_timer.sv | 26 ++
 rtl/ov7670_power_seq.sv | 123 ++++++++++++
 tb/tb_ov7670_power_seq.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/ov7670_power_seq_pkg.sv
// rtl/ov7670_power_seq_pkg.sv - state encoding, pin decode and default timings for the OV7670 power sequencer
package ov7670_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PWDN_HOLD = 3'd1,
    RST_HOLD  = 3'd2,
    SETTLE    = 3'd3,
    CFG_WAIT  = 3'd4,
    READY     = 3'd5,
    ERROR     = 3'd6
  } state_t;

  typedef struct packed {
    logic pwdn;
    logic resetb;
    logic ready;
    logic busy;
    logic error;
  } pins_t;

  // pwdn, resetb, ready, busy, error
  localparam pins_t OUT_IDLE   = 5'b1_0_0_0_0;
  localparam pins_t OUT_PWDN   = 5'b1_0_0_1_0;
  localparam pins_t OUT_RST    = 5'b0_0_0_1_0;
  localparam pins_t OUT_SETTLE = 5'b0_1_0_1_0;
  localparam pins_t OUT_CFG    = 5'b0_1_0_1_0;
  localparam pins_t OUT_READY  = 5'b0_1_1_0_0;
  localparam pins_t OUT_ERROR  = 5'b1_0_0_0_1;

  localparam int PWDN_CYCLES_50M   = 1000000;
  localparam int RST_CYCLES_50M    = 100000;
  localparam int SETTLE_CYCLES_50M = 2000000;
  localparam int CFG_TIMEOUT_50M   = 16000000;

  localparam int PWDN_CYCLES_25M   = 500000;
  localparam int RST_CYCLES_25M    = 50000;
  localparam int SETTLE_CYCLES_25M = 1000000;
  localparam int CFG_TIMEOUT_25M   = 8000000;

  function automatic pins_t decode(input state_t s);
    case (s)
      PWDN_HOLD: return OUT_PWDN;
      RST_HOLD:  return OUT_RST;
      SETTLE:    return OUT_SETTLE;
      CFG_WAIT:  return OUT_CFG;
      READY:     return OUT_READY;
      ERROR:     return OUT_ERROR;
      default:   return OUT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ov7670_power_seq_if.sv
// rtl/ov7670_power_seq_if.sv - control, camera pin and status bundle of the power sequencer
interface ov7670_power_seq_if #(
  parameter int MAX_RETRY = 3
);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  logic               en;
  logic               restart;
  logic               cfg_done;
  logic               cam_pwdn;
  logic               cam_resetb;
  logic               cfg_start;
  logic               ready;
  logic               busy;
  logic               error;
  logic [RETRY_W-1:0] retry_cnt;

  modport master (
    input  en, restart, cfg_done,
    output cam_pwdn, cam_resetb, cfg_start, ready, busy, error, retry_cnt
  );

  modport slave (
    output en, restart, cfg_done,
    input  cam_pwdn, cam_resetb, cfg_start, ready, busy, error, retry_cnt
  );
endinterface

// File: rtl/ov7670_power_seq_timer.sv
// rtl/ov7670_power_seq_timer.sv - shared stage/timeout counter with terminal match
module seq_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // limit is the last count of the stage (cycles - 1)
  assign done = (cnt == limit);
endmodule

// File: rtl/ov7670_power_seq.sv
// rtl/ov7670_power_seq.sv - staged PWDN/RESETB power-up sequencer with supervised SCCB configuration
module ov7670_power_seq
  import ov7670_seq_pkg::*;
#(
  parameter int CNT_W         = 24,
  parameter int PWDN_CYCLES   = 1000000,
  parameter int RST_CYCLES    = 100000,
  parameter int SETTLE_CYCLES = 2000000,
  parameter int CFG_TIMEOUT   = 16000000,
  parameter int MAX_RETRY     = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ov7670_power_seq_if.master       bus
);
  localparam int RW = $clog2(MAX_RETRY + 1);

  state_t           state;
  state_t           nxt;
  logic [RW-1:0]    retry;
  logic [RW-1:0]    retry_nxt;
  logic             enter;
  logic             timed;
  logic             done;
  logic [CNT_W-1:0] limit;
  pins_t            pins;
  logic             cfg_start;

  always_comb begin
    limit = '0;
    case (state)
      PWDN_HOLD: limit = CNT_W'(PWDN_CYCLES - 1);
      RST_HOLD:  limit = CNT_W'(RST_CYCLES - 1);
      SETTLE:    limit = CNT_W'(SETTLE_CYCLES - 1);
      CFG_WAIT:  limit = CNT_W'(CFG_TIMEOUT - 1);
      default:   limit = '0;
    endcase
  end

  assign timed = (state inside {PWDN_HOLD, RST_HOLD, SETTLE, CFG_WAIT});

  // enter also fires on self-loops (held restart, retry) so the timer restarts from 0
  always_comb begin
    nxt       = state;
    retry_nxt = retry;
    enter     = 1'b0;
    if (!bus.en) begin
      nxt       = IDLE;
      retry_nxt = '0;
      enter     = (state != IDLE);
    end else if (bus.restart && state != IDLE) begin
      nxt       = PWDN_HOLD;
      retry_nxt = '0;
      enter     = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          nxt   = PWDN_HOLD;
          enter = 1'b1;
        end
        PWDN_HOLD: if (done) begin
          nxt   = RST_HOLD;
          enter = 1'b1;
        end
        RST_HOLD: if (done) begin
          nxt   = SETTLE;
          enter = 1'b1;
        end
        SETTLE: if (done) begin
          nxt   = CFG_WAIT;
          enter = 1'b1;
        end
        CFG_WAIT: begin
          if (bus.cfg_done) begin
            nxt       = READY;
            retry_nxt = '0;
            enter     = 1'b1;
          end else if (done) begin
            enter = 1'b1;
            if (retry < RW'(MAX_RETRY)) begin
              nxt       = PWDN_HOLD;
              retry_nxt = retry + RW'(1);
            end else begin
              nxt = ERROR;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      retry     <= '0;
      pins      <= OUT_IDLE;
      cfg_start <= 1'b0;
    end else begin
      state     <= nxt;
      retry     <= retry_nxt;
      pins      <= decode(nxt);
      cfg_start <= enter && (nxt == CFG_WAIT);
    end
  end

  seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (enter),
    .inc   (timed),
    .limit (limit),
    .done  (done)
  );

  assign bus.cam_pwdn   = pins.pwdn;
  assign bus.cam_resetb = pins.resetb;
  assign bus.ready      = pins.ready;
  assign bus.busy       = pins.busy;
  assign bus.error      = pins.error;
  assign bus.cfg_start  = cfg_start;
  assign bus.retry_cnt  = retry;
endmodule

// File: tb/tb_ov7670_power_seq.sv
// tb/tb_ov7670_power_seq.sv - vector table, corner sequences and random run against a timeline model
module tb_ov7670_power_seq;
  localparam int P  = 4;
  localparam int R  = 3;
  localparam int S  = 5;
  localparam int C  = 8;
  localparam int MR = 2;
  localparam int CW = 8;
  localparam int TOTAL = P + R + S + C;

  localparam int M_IDLE = 0;
  localparam int M_SEQ  = 1;
  localparam int M_RDY  = 2;
  localparam int M_ERR  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ov7670_power_seq_if #(.MAX_RETRY(MR)) bus ();

  ov7670_power_seq #(
    .CNT_W(CW), .PWDN_CYCLES(P), .RST_CYCLES(R), .SETTLE_CYCLES(S),
    .CFG_TIMEOUT(C), .MAX_RETRY(MR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         n;
    logic       en;
    logic       restart;
    logic       done;
    logic [7:0] exp;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // model: mode plus time since the current attempt began
  int m_mode = M_IDLE;
  int m_t    = 0;
  int m_retry = 0;

  function automatic logic [7:0] o(input logic pw, rb, rdy, bsy, err, cs, input int r);
    logic [1:0] rr;
    rr = 2'(r);
    return {pw, rb, rdy, bsy, err, cs, rr};
  endfunction

  function automatic logic [7:0] v_idle();        return o(1,0,0,0,0,0,0); endfunction
  function automatic logic [7:0] v_pwdn(int r);   return o(1,0,0,1,0,0,r); endfunction
  function automatic logic [7:0] v_rst(int r);    return o(0,0,0,1,0,0,r); endfunction
  function automatic logic [7:0] v_settle(int r); return o(0,1,0,1,0,0,r); endfunction
  function automatic logic [7:0] v_cfg(logic cs, int r); return o(0,1,0,1,0,cs,r); endfunction
  function automatic logic [7:0] v_ready();       return o(0,1,1,0,0,0,0); endfunction
  function automatic logic [7:0] v_error(int r);  return o(1,0,0,0,1,0,r); endfunction

  function automatic logic [7:0] actual();
    return {bus.cam_pwdn, bus.cam_resetb, bus.ready, bus.busy, bus.error,
            bus.cfg_start, bus.retry_cnt};
  endfunction

  function automatic logic [7:0] model_out();
    logic pw, rb, cs;
    pw = (m_mode == M_IDLE) || (m_mode == M_ERR) || (m_mode == M_SEQ && m_t < P);
    rb = (m_mode == M_SEQ && m_t >= P + R) || (m_mode == M_RDY);
    cs = (m_mode == M_SEQ && m_t == P + R + S);
    return o(pw, rb, m_mode == M_RDY, m_mode == M_SEQ, m_mode == M_ERR, cs, m_retry);
  endfunction

  function automatic void model_step(input logic e, r, d);
    if (!e) begin
      m_mode = M_IDLE; m_retry = 0; m_t = 0;
    end else if (r && m_mode != M_IDLE) begin
      m_mode = M_SEQ; m_t = 0; m_retry = 0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_SEQ; m_t = 0;
    end else if (m_mode == M_SEQ) begin
      if (d && m_t >= P + R + S) begin
        m_mode = M_RDY; m_retry = 0;
      end else if (m_t == TOTAL - 1) begin
        if (m_retry < MR) begin
          m_retry = m_retry + 1; m_t = 0;
        end else begin
          m_mode = M_ERR;
        end
      end else begin
        m_t = m_t + 1;
      end
    end
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got pwdn,resetb,ready,busy,error,cfg_start,retry=%b want %b at %0t",
               name, got, want, $time);
    end
  endtask

  task automatic step(input logic e, r, d);
    bus.en = e; bus.restart = r; bus.cfg_done = d;
    @(posedge clk);
    model_step(e, r, d);
    @(negedge clk);
    check("model", actual(), model_out());
  endtask

  task automatic add(input int n, input logic e, r, d, input logic [7:0] exp);
    vec_t v;
    v.n = n; v.en = e; v.restart = r; v.done = d; v.exp = exp;
    vq.push_back(v);
  endtask

  initial begin
    bus.en = 1'b0; bus.restart = 1'b0; bus.cfg_done = 1'b0;

    // nominal bring-up, cfg_done ignored in SETTLE
    add(1, 1,0,0, v_pwdn(0));
    add(3, 1,0,0, v_pwdn(0));
    add(1, 1,0,0, v_rst(0));
    add(2, 1,0,0, v_rst(0));
    add(1, 1,0,0, v_settle(0));
    add(4, 1,0,1, v_settle(0));
    add(1, 1,0,0, v_cfg(1, 0));
    add(1, 1,0,0, v_cfg(0, 0));
    add(1, 1,0,0, v_cfg(0, 0));
    add(1, 1,0,1, v_ready());
    add(3, 1,0,1, v_ready());
    // restart from READY, then timeouts to ERROR
    add(1, 1,1,0, v_pwdn(0));
    add(20, 1,0,0, v_pwdn(1));
    add(19, 1,0,0, v_cfg(0, 1));
    add(1, 1,0,0, v_pwdn(2));
    add(20, 1,0,0, v_error(2));
    add(2, 1,0,1, v_error(2));
    add(1, 1,1,0, v_pwdn(0));
    add(1, 0,0,0, v_idle());
    add(2, 0,1,0, v_idle());
    // cfg_done on the timeout cycle wins
    add(1, 1,0,0, v_pwdn(0));
    add(19, 1,0,0, v_cfg(0, 0));
    add(1, 1,0,1, v_ready());
    // abort mid-SETTLE, then a clean re-run
    add(1, 1,1,0, v_pwdn(0));
    add(9, 1,0,0, v_settle(0));
    add(1, 0,0,0, v_idle());
    add(1, 1,0,0, v_pwdn(0));
    add(3, 1,0,0, v_pwdn(0));
    add(1, 1,0,0, v_rst(0));
    add(3, 1,0,0, v_settle(0));
    add(4, 1,0,0, v_settle(0));
    add(1, 1,0,0, v_cfg(1, 0));
    add(1, 1,1,1, v_pwdn(0));

    repeat (2) @(negedge clk);
    check("reset", actual(), v_idle());
    rst_n = 1'b1;

    foreach (vq[i]) begin
      for (int k = 0; k < vq[i].n; k++) step(vq[i].en, vq[i].restart, vq[i].done);
      check($sformatf("vec%0d", i), actual(), vq[i].exp);
    end

    // async reset in RST_HOLD without a clock edge
    step(0, 0, 0);
    for (int k = 0; k < 5; k++) step(1, 0, 0);
    check("pre_async", actual(), v_rst(0));
    #2 rst_n = 1'b0;
    #1 check("async_reset", actual(), v_idle());
    m_mode = M_IDLE; m_t = 0; m_retry = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0);
    check("post_reset", actual(), v_pwdn(0));
    for (int k = 0; k < 4; k++) step(1, 0, 0);
    check("post_reset_rst", actual(), v_rst(0));

    // held restart keeps the sequence pinned in PWDN_HOLD
    for (int k = 0; k < 6; k++) step(1, 1, 0);
    check("held_restart", actual(), v_pwdn(0));

    for (int k = 0; k < 2500; k++) begin
      step($urandom_range(0, 31) != 0, $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
